div_unit: RTL



---
 rtl/alu_pkg.sv | 15 +
 rtl/div_trial_sub.sv | 19 +
 rtl/div_unit.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the calculator arithmetic unit: divider state
// encoding, iteration count and the divide-by-zero quotient pattern.
package alu_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } div_state_t;

    localparam int DIV_STEPS = 8;
    localparam int DIV_CNT_W = $clog2(DIV_STEPS);
    localparam logic [7:0] DIV0_QUOTIENT = 8'hFF;

endpackage

// File: rtl/div_trial_sub.sv
// Combinational W-bit trial subtract for the divider, built as
// minuend + ~subtrahend + 1 so it matches the adder path's formulation.
module div_trial_sub #(
    parameter int W = 9
) (
    input  logic [W-1:0] minuend_i,
    input  logic [W-1:0] subtrahend_i,
    output logic [W-1:0] diff_o,
    output logic         borrow_o
);

    logic [W:0] sum_s;

    // A missing carry-out of the inverted-operand add means the subtract borrowed.
    assign sum_s    = {1'b0, minuend_i} + {1'b0, ~subtrahend_i} + {{W{1'b0}}, 1'b1};
    assign diff_o   = sum_s[W-1:0];
    assign borrow_o = ~sum_s[W];

endmodule

// File: rtl/div_unit.sv
// Sequential unsigned restoring divider: one quotient bit per clock, results
// and flags registered and announced with a one-cycle done pulse.
module div_unit
    import alu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] A_in,
    input  logic [WIDTH-1:0] B_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] Quotient,
    output logic [WIDTH-1:0] Remainder,
    output logic             DIV0,
    output logic             ZERO
);

    div_state_t             state_q, state_d;
    logic [WIDTH-1:0]       q_q, q_d;
    logic [WIDTH-1:0]       d_q, d_d;
    logic [WIDTH:0]         rem_q, rem_d;
    logic [DIV_CNT_W-1:0]   cnt_q, cnt_d;
    logic                   div0_pend_q, div0_pend_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;
    logic [WIDTH-1:0]       quot_q, quot_d;
    logic [WIDTH-1:0]       remo_q, remo_d;
    logic                   div0_q, div0_d;
    logic                   zero_q, zero_d;

    logic [2*WIDTH:0]       shift_pair_s;
    logic [WIDTH:0]         shift_rem_s;
    logic [WIDTH:0]         trial_s;
    logic                   borrow_s;

    // The partial remainder and quotient shift together as one wide register.
    assign shift_pair_s = {rem_q, q_q} << 1;
    assign shift_rem_s  = shift_pair_s[2*WIDTH:WIDTH];

    div_trial_sub #(
        .W (WIDTH + 1)
    ) u_trial (
        .minuend_i    (shift_rem_s),
        .subtrahend_i ({1'b0, d_q}),
        .diff_o       (trial_s),
        .borrow_o     (borrow_s)
    );

    // Next-state, datapath and output-register updates for the divider FSM.
    always_comb begin
        state_d     = state_q;
        q_d         = q_q;
        d_d         = d_q;
        rem_d       = rem_q;
        cnt_d       = cnt_q;
        div0_pend_d = div0_pend_q;
        busy_d      = 1'b0;
        done_d      = 1'b0;
        quot_d      = quot_q;
        remo_d      = remo_q;
        div0_d      = div0_q;
        zero_d      = zero_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    if (B_in != {WIDTH{1'b0}}) begin
                        q_d         = A_in;
                        d_d         = B_in;
                        rem_d       = {(WIDTH+1){1'b0}};
                        cnt_d       = {DIV_CNT_W{1'b0}};
                        div0_pend_d = 1'b0;
                        state_d     = CALC;
                    end else begin
                        // Divide by zero skips iteration and reports the dividend back.
                        q_d         = WIDTH'(DIV0_QUOTIENT);
                        rem_d       = {1'b0, A_in};
                        div0_pend_d = 1'b1;
                        state_d     = DONE;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            CALC: begin
                busy_d = 1'b1;
                if (borrow_s) begin
                    rem_d = shift_rem_s;
                end else begin
                    rem_d = trial_s;
                end
                q_d   = shift_pair_s[WIDTH-1:0] | {{(WIDTH-1){1'b0}}, ~borrow_s};
                cnt_d = cnt_q + {{(DIV_CNT_W-1){1'b0}}, 1'b1};
                if (cnt_q == DIV_CNT_W'(DIV_STEPS - 1)) begin
                    state_d = DONE;
                end else begin
                    state_d = CALC;
                end
            end
            DONE: begin
                done_d  = 1'b1;
                quot_d  = q_q;
                remo_d  = rem_q[WIDTH-1:0];
                div0_d  = div0_pend_q;
                zero_d  = (q_q == {WIDTH{1'b0}});
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and result registers; reset wins over any request in the same cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            q_q         <= {WIDTH{1'b0}};
            d_q         <= {WIDTH{1'b0}};
            rem_q       <= {(WIDTH+1){1'b0}};
            cnt_q       <= {DIV_CNT_W{1'b0}};
            div0_pend_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            quot_q      <= {WIDTH{1'b0}};
            remo_q      <= {WIDTH{1'b0}};
            div0_q      <= 1'b0;
            zero_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            q_q         <= q_d;
            d_q         <= d_d;
            rem_q       <= rem_d;
            cnt_q       <= cnt_d;
            div0_pend_q <= div0_pend_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            quot_q      <= quot_d;
            remo_q      <= remo_d;
            div0_q      <= div0_d;
            zero_q      <= zero_d;
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign Quotient  = quot_q;
    assign Remainder = remo_q;
    assign DIV0      = div0_q;
    assign ZERO      = zero_q;

endmodule
